spm_offset_slew_ctrl: RTL

- Sequencer that moves the absolute scan offset vector (x0, y0, z0) fed to the SPM scan/feedback datapath.
- Ramps the offset from its current value to a host-commanded target at a limited step rate, then waits a settle time and reports completion.
- Prevents piezo jumps when the host re-positions the scan window. Sits between the host register bank and the x0/y0/z0 inputs of the scan datapath.

---
 rtl/spm_offset_slew_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spm_offset_slew_ctrl.sv
// Slew-limited sequencer for the SPM scan offset vector (x0, y0, z0): ramps to a
// host target at a bounded per-tick step, waits a settle time, then reports done.
module spm_offset_slew_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DECI_BITS   = 4,
  parameter int SETTLE_BITS = 16
) (
  input  logic                     a_clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [WIDTH-1:0]  target_x,
  input  logic signed [WIDTH-1:0]  target_y,
  input  logic signed [WIDTH-1:0]  target_z,
  input  logic [WIDTH-1:0]         step_xy,
  input  logic [WIDTH-1:0]         step_z,
  input  logic [SETTLE_BITS-1:0]   settle_cyc,
  input  logic                     abort,
  output logic signed [WIDTH-1:0]  x0,
  output logic signed [WIDTH-1:0]  y0,
  output logic signed [WIDTH-1:0]  z0,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [DECI_BITS-1:0]     tick_cnt_q, tick_cnt_d;
  logic signed [WIDTH-1:0]  x0_q, x0_d, y0_q, y0_d, z0_q, z0_d;
  logic [SETTLE_BITS-1:0]   settle_cnt_q, settle_cnt_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     aborted_q, aborted_d;

  logic signed [WIDTH-1:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d, tgt_z_q, tgt_z_d;
  logic [WIDTH-1:0]         stp_xy_q, stp_xy_d, stp_z_q, stp_z_d;
  logic [SETTLE_BITS-1:0]   settle_q, settle_d;

  logic                     tick;
  logic signed [WIDTH-1:0]  nx_x, nx_y, nz_z;

  // Top bit of the step word is ignored so a step never reads as negative; zero means one.
  function automatic logic [WIDTH-1:0] norm_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] m;
    m = {1'b0, s[WIDTH-2:0]};
    if (m == '0) m = {{(WIDTH-1){1'b0}}, 1'b1};
    return m;
  endfunction

  // Difference is taken one bit wider so the magnitude compare never overflows;
  // a partial step always lands strictly between cur and tgt, so it cannot wrap.
  function automatic logic signed [WIDTH-1:0] slew_axis(
    input logic signed [WIDTH-1:0] cur,
    input logic signed [WIDTH-1:0] tgt,
    input logic [WIDTH-1:0]        step
  );
    logic signed [WIDTH:0] d;
    logic [WIDTH:0]        du;
    logic [WIDTH:0]        mag;
    d   = {tgt[WIDTH-1], tgt} - {cur[WIDTH-1], cur};
    du  = $unsigned(d);
    mag = d[WIDTH] ? (~du + {{WIDTH{1'b0}}, 1'b1}) : du;
    if (mag <= {1'b0, step}) return tgt;
    else if (!d[WIDTH])      return cur + $signed(step);
    else                     return cur - $signed(step);
  endfunction

  assign tick = (tick_cnt_q == {DECI_BITS{1'b1}});
  assign nx_x = slew_axis(x0_q, tgt_x_q, stp_xy_q);
  assign nx_y = slew_axis(y0_q, tgt_y_q, stp_xy_q);
  assign nz_z = slew_axis(z0_q, tgt_z_q, stp_z_q);

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q + DECI_BITS'(1);
    x0_d         = x0_q;
    y0_d         = y0_q;
    z0_d         = z0_q;
    settle_cnt_d = settle_cnt_q;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    tgt_z_d      = tgt_z_q;
    stp_xy_d     = stp_xy_q;
    stp_z_d      = stp_z_q;
    settle_d     = settle_q;
    aborted_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          tgt_x_d  = target_x;
          tgt_y_d  = target_y;
          tgt_z_d  = target_z;
          stp_xy_d = norm_step(step_xy);
          stp_z_d  = norm_step(step_z);
          settle_d = settle_cyc;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (tick) begin
          x0_d = nx_x;
          y0_d = nx_y;
          z0_d = nz_z;
          if ((nx_x == tgt_x_q) && (nx_y == tgt_y_q) && (nz_z == tgt_z_q)) begin
            settle_cnt_d = settle_q;
            state_d      = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (settle_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_BITS'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_MOVE) || (state_d == S_SETTLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      z0_q         <= '0;
      settle_cnt_q <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      z0_q         <= z0_d;
      settle_cnt_q <= settle_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  // Command latches are only meaningful after an accepted command, so they carry no reset.
  always_ff @(posedge a_clk) begin
    tgt_x_q  <= tgt_x_d;
    tgt_y_q  <= tgt_y_d;
    tgt_z_q  <= tgt_z_d;
    stp_xy_q <= stp_xy_d;
    stp_z_q  <= stp_z_d;
    settle_q <= settle_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign x0        = x0_q;
  assign y0        = y0_q;
  assign z0        = z0_q;

endmodule
